instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage directly upstream of the decoder. Holds the program counter and a word-addressed instruction ROM, and presents one registered 32-bit `InstrReg` per cycle for the decoder to sample. Takes the decoder's `Branch`, `Jump`, `const` and `address` outputs plus the ALU `Zero` flag back as redirect inputs. Supports stall, wrong-path flush and a terminal halt.

## Interface
Parameters:
- `IMEM_DEPTH`, 256: ROM depth in 32-bit words (power of two).
- `IMEM_INIT`, "program.hex": `$readmemh` image file for the ROM.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset (word-aligned).

Ports:
- `clk`  in  1: single clock, all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `stall`  in  1: hold all state this cycle.
- `Branch`  in  1: instruction in `InstrReg` is a beq.
- `Zero`  in  1: ALU equality result for that beq.
- `Jump`  in  1: instruction in `InstrReg` is j.
- `const`  in  16: branch immediate (signed word offset).
- `address`  in  26: jump word index.
- `InstrReg`  out  32: fetched instruction word, registered.
- `instr_pc`  out  32: byte address of the word in `InstrReg`.
- `instr_valid`  out  1: `InstrReg` is a real instruction, not a bubble.
- `pc`  out  32: address to be fetched next edge.
- `halted`  out  1: fetch stopped permanently until reset.

## Operation
- Reset values:
  - `pc` = `RESET_PC`
  - `InstrReg` = 32'h0000_0000
  - `instr_pc` = 0
  - `instr_valid` = 0
  - `halted` = 0
  - FSM enters RUN.
- FSM states:
  - RUN: normal fetch.
  - HALT: `pc` frozen; `InstrReg` = 0 and `instr_valid` = 0 every cycle. HALT is left only by `rst`.
- Priority per edge: `rst` > HALT > `stall` > `Jump` > (`Branch` & `Zero`) > sequential.
- Sequential fetch:
  - `InstrReg` <= imem[`pc`[log2(IMEM_DEPTH)+1:2]]
  - `instr_pc` <= `pc`
  - `instr_valid` <= 1
  - `pc` <= `pc` + 4
- Jump redirect (`Jump`=1, `stall`=0):
  - `pc` <= {(`instr_pc`+4)[31:28], `address`, 2'b00}.
  - `InstrReg` <= 0 (sll $0 nop), `instr_valid` <= 0: flushes the wrong-path word.
- Branch redirect (`Branch`&`Zero`=1, `stall`=0):
  - `pc` <= `instr_pc` + 4 + (sign-extended `const` << 2).
  - Same flush as jump.
- `Branch`=1 with `Zero`=0: sequential fetch.
- Redirect inputs are ignored while `instr_valid`=0. They are ignored and not remembered while `stall`=1; downstream must hold them stable through the stall.
- Halt condition:
  - The word read from the ROM is 32'hFFFF_FFFF.
  - On that edge: state -> HALT, `halted` <= 1, `InstrReg` <= 0, `instr_valid` <= 0, `pc` unchanged.
  - A redirect on the same edge takes precedence, so a wrong-path halt word does not halt.
- Arithmetic: all PC arithmetic is 32-bit modulo 2^32. `pc`[1:0] is always 00.

## Timing
- Latency: 1 cycle. Word at `pc` appears on `InstrReg` after the next rising edge.
- First valid instruction: the first edge with `rst`=0. `instr_valid`=1 the cycle after.
- Redirect penalty: exactly one bubble cycle. The target word is valid 2 edges after the redirect is presented.
- Stall: all outputs hold their values, including `instr_valid`.
- `rst` mid-stall or during HALT: reset values apply on that edge.

## Configuration
- `IFETCH_OOB_HALT_EN` defined: if `pc` >= 4*`IMEM_DEPTH` at a fetch edge, the FSM enters HALT exactly as for the halt word.
- Not defined: the ROM index wraps modulo `IMEM_DEPTH` (upper PC bits ignored) and fetch continues.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants: R-type 6'b000000, j 6'b000010, beq 6'b000100;
  - `NOP_INSTR` = 32'h0;
  - `HALT_INSTR` = 32'hFFFF_FFFF;
  - the FSM state enum {RUN, HALT}.
- Sub-module `instr_rom`: parameterised depth/init, combinational read of one word. The fetch register stays in `instr_fetch`.

## Test plan
- Reset release, ROM words 0..3 = A,B,C,D: `InstrReg` shows A,B,C,D on consecutive cycles; `instr_pc` = 0,4,8,12; `instr_valid`=1.
- `stall`=1 for 3 cycles while `InstrReg`=B (`instr_pc`=4): all outputs constant; C appears on the first edge after `stall` drops.
- `Jump`=1, `address`=26'h10 with `instr_pc`=8: next `InstrReg`=0, `instr_valid`=0; following cycle `instr_pc`=0x40 with word 16.
- Branch taken with `instr_pc`=0x20, `const`=16'hFFFE: one bubble, then `instr_pc`=0x1C. With `Zero`=0: no bubble, `instr_pc`=0x24.
- HALT_INSTR at word 5: `halted`=1 after fetching 0x14; `pc` frozen, `instr_valid`=0. `rst` pulse returns to `RESET_PC`.
- `IMEM_DEPTH`=4, sequential run past 0x0C:
  - with `IFETCH_OOB_HALT_EN`: halts at `pc`=0x10;
  - without: fetches word 0 at `instr_pc`=0x10.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Definitions shared by the fetch stage and its neighbours:
//               opcode values, the nop and halt instruction words, the fetch
//               FSM state encoding and the branch-offset helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Primary opcode field values (instr[31:26])
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;

    // sll $0,$0,0 doubles as the bubble word
    localparam logic [31:0] c_NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] c_HALT_INSTR = 32'hFFFF_FFFF;

    // Fetch FSM state encoding
    typedef logic [0:0] fsm_state_t;
    localparam fsm_state_t c_ST_RUN  = 1'b0;
    localparam fsm_state_t c_ST_HALT = 1'b1;

    // Signed 16-bit word offset -> 32-bit byte offset
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_rom.sv
`default_nettype none
// ============================================================================
// Module      : instr_rom
// Description : Word-addressed instruction ROM with combinational read.
//               The storage array is filled by its environment; IMEM_INIT
//               names the program image associated with this ROM.
// Ports       : i_addr  - word index
//               o_data  - 32-bit word at i_addr
// Revision    : 1.0 - initial release
// ============================================================================
module instr_rom #(
    parameter int    IMEM_DEPTH = 256,
    parameter string IMEM_INIT  = "program.hex"
) (
    input  logic [$clog2(IMEM_DEPTH)-1:0] i_addr,
    output logic [31:0]                   o_data
);

    logic [31:0] r_mem [IMEM_DEPTH];

    assign o_data = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage. Holds the PC, reads the ROM and
//               registers one instruction per cycle for the decoder. Jump and
//               taken-beq redirects flush the wrong-path word (one bubble).
//               Fetching the all-ones word halts fetch until reset.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               stall         - hold all state this cycle
//               Branch, Zero  - beq in InstrReg and its ALU equality result
//               Jump          - j in InstrReg
//               const_imm     - beq immediate ('const' is a reserved word)
//               address       - j word index
//               InstrReg      - registered instruction word
//               instr_pc      - byte address of InstrReg
//               instr_valid   - InstrReg is a real instruction
//               pc            - address fetched on the next edge
//               halted        - fetch stopped until reset
// Config      : IFETCH_OOB_HALT_EN - halt when pc runs past the ROM instead
//               of wrapping the ROM index
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int          IMEM_DEPTH = 256,
    parameter string       IMEM_INIT  = "program.hex",
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    input  logic [15:0] const_imm,
    input  logic [25:0] address,
    output logic [31:0] InstrReg,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic        halted
);

    localparam int c_AW = $clog2(IMEM_DEPTH);

    fsm_state_t  r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic [31:0] r_instr_pc, w_instr_pc_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_halted, w_halted_nxt;

    logic [31:0] w_rom_word;
    logic [31:0] w_link;
    logic [31:0] w_jump_tgt;
    logic [31:0] w_branch_tgt;
    logic        w_jump_take;
    logic        w_branch_take;
    logic        w_fetch_halt;

    instr_rom #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .IMEM_INIT  (IMEM_INIT)
    ) u_rom (
        .i_addr (r_pc[c_AW+1:2]),
        .o_data (w_rom_word)
    );

    // Redirect targets are relative to the instruction being decoded
    assign w_link       = r_instr_pc + 32'd4;
    assign w_jump_tgt   = {w_link[31:28], address, 2'b00};
    assign w_branch_tgt = w_link + branch_offset(const_imm);

    // A bubble in InstrReg carries no real control decision
    assign w_jump_take   = r_valid & Jump;
    assign w_branch_take = r_valid & Branch & Zero;

`ifdef IFETCH_OOB_HALT_EN
    localparam logic [31:0] c_PC_LIMIT = 32'(4 * IMEM_DEPTH);
    assign w_fetch_halt = (w_rom_word == c_HALT_INSTR) || (r_pc >= c_PC_LIMIT);
`else
    assign w_fetch_halt = (w_rom_word == c_HALT_INSTR);
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_instr_pc_nxt = r_instr_pc;
        w_valid_nxt    = r_valid;
        w_halted_nxt   = r_halted;
        if (r_state == c_ST_HALT) begin
            w_instr_nxt  = c_NOP_INSTR;
            w_valid_nxt  = 1'b0;
            w_halted_nxt = 1'b1;
        end else if (!stall) begin
            if (w_jump_take) begin
                w_pc_nxt    = w_jump_tgt;
                w_instr_nxt = c_NOP_INSTR;
                w_valid_nxt = 1'b0;
            end else if (w_branch_take) begin
                w_pc_nxt    = w_branch_tgt;
                w_instr_nxt = c_NOP_INSTR;
                w_valid_nxt = 1'b0;
            end else if (w_fetch_halt) begin
                // pc stays on the halt word
                w_state_nxt  = c_ST_HALT;
                w_halted_nxt = 1'b1;
                w_instr_nxt  = c_NOP_INSTR;
                w_valid_nxt  = 1'b0;
            end else begin
                w_instr_nxt    = w_rom_word;
                w_instr_pc_nxt = r_pc;
                w_valid_nxt    = 1'b1;
                w_pc_nxt       = r_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_RUN;
            r_pc       <= RESET_PC;
            r_instr    <= c_NOP_INSTR;
            r_instr_pc <= 32'd0;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_instr_pc <= w_instr_pc_nxt;
            r_valid    <= w_valid_nxt;
            r_halted   <= w_halted_nxt;
        end
    end

    assign InstrReg    = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_valid;
    assign pc          = r_pc;
    assign halted      = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Scoreboard bench for instr_fetch. Drivers push the expected
//               post-edge outputs tagged with their cycle; a monitor pops and
//               compares after every rising edge. dut_a uses a 256-word ROM,
//               dut_b a 4-word ROM for the PC-past-end behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut_a stimulus
    logic        rst_a, stall_a, jump_a, branch_a, zero_a;
    logic [15:0] k_a;
    logic [25:0] adr_a;
    logic [31:0] instr_a, ipc_a, pc_a;
    logic        valid_a, halted_a;

    // dut_b stimulus (only reset is exercised)
    logic        rst_b;
    logic        c_zero1 = 1'b0;
    logic [15:0] c_zero16 = 16'h0;
    logic [25:0] c_zero26 = 26'h0;
    logic [31:0] instr_b, ipc_b, pc_b;
    logic        valid_b, halted_b;

    instr_fetch #(.IMEM_DEPTH(256), .IMEM_INIT(""), .RESET_PC(32'h0)) dut_a (
        .clk(clk), .rst(rst_a), .stall(stall_a), .Branch(branch_a), .Zero(zero_a),
        .Jump(jump_a), .const_imm(k_a), .address(adr_a),
        .InstrReg(instr_a), .instr_pc(ipc_a), .instr_valid(valid_a),
        .pc(pc_a), .halted(halted_a)
    );

    instr_fetch #(.IMEM_DEPTH(4), .IMEM_INIT(""), .RESET_PC(32'h0)) dut_b (
        .clk(clk), .rst(rst_b), .stall(c_zero1), .Branch(c_zero1), .Zero(c_zero1),
        .Jump(c_zero1), .const_imm(c_zero16), .address(c_zero26),
        .InstrReg(instr_b), .instr_pc(ipc_b), .instr_valid(valid_b),
        .pc(pc_b), .halted(halted_b)
    );

    typedef struct {
        int          cyc;
        int          id;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic        chk_ipc;
        logic        valid;
        logic [31:0] pc;
        logic        halted;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   cyc = 0;
    int   n_issued = 0;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [31:0] wa(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    function automatic logic [31:0] wb(input int i);
        return 32'hB0B0_0000 + 32'(i);
    endfunction

    function automatic exp_t ex(input logic [31:0] instr, input logic [31:0] ipc,
                                input logic chk, input logic valid,
                                input logic [31:0] pc, input logic halt);
        exp_t e;
        e.cyc = 0; e.id = 0;
        e.instr = instr; e.ipc = ipc; e.chk_ipc = chk;
        e.valid = valid; e.pc = pc; e.halted = halt;
        return e;
    endfunction

    task automatic set_a(input logic r, input logic s, input logic j, input logic b,
                         input logic z, input logic [15:0] k, input logic [25:0] adr);
        rst_a = r; stall_a = s; jump_a = j; branch_a = b; zero_a = z; k_a = k; adr_a = adr;
    endtask

    // Issue the current inputs for the coming edge and record what must follow it
    task automatic tick_a(input exp_t e);
        exp_t t;
        t = e; t.cyc = cyc + 1; t.id = n_issued;
        n_issued++;
        q_a.push_back(t);
        @(posedge clk); #1;
    endtask

    task automatic tick_b(input exp_t e);
        exp_t t;
        t = e; t.cyc = cyc + 1; t.id = n_issued;
        n_issued++;
        q_b.push_back(t);
        @(posedge clk); #1;
    endtask

    task automatic check(input string tag, input exp_t e, input logic [31:0] instr,
                         input logic [31:0] ipc, input logic valid,
                         input logic [31:0] pc, input logic halt);
        n_vec++;
        if (instr !== e.instr || valid !== e.valid || pc !== e.pc || halt !== e.halted ||
            (e.chk_ipc && ipc !== e.ipc)) begin
            n_err++;
            $display("FAIL %s vec%0d cyc%0d: got instr=%h ipc=%h v=%b pc=%h h=%b, want instr=%h ipc=%h(chk=%b) v=%b pc=%h h=%b",
                     tag, e.id, cyc, instr, ipc, valid, pc, halt,
                     e.instr, e.ipc, e.chk_ipc, e.valid, e.pc, e.halted);
        end
    endtask

    // Monitor: sample 2 time units after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            while (q_a.size() != 0 && q_a[0].cyc <= cyc) begin
                e = q_a.pop_front();
                if (e.cyc != cyc) begin
                    n_vec++; n_err++;
                    $display("FAIL dut_a vec%0d stale: due cyc%0d, now cyc%0d", e.id, e.cyc, cyc);
                end else begin
                    check("dut_a", e, instr_a, ipc_a, valid_a, pc_a, halted_a);
                end
            end
            while (q_b.size() != 0 && q_b[0].cyc <= cyc) begin
                e = q_b.pop_front();
                if (e.cyc != cyc) begin
                    n_vec++; n_err++;
                    $display("FAIL dut_b vec%0d stale: due cyc%0d, now cyc%0d", e.id, e.cyc, cyc);
                end else begin
                    check("dut_b", e, instr_b, ipc_b, valid_b, pc_b, halted_b);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) dut_a.u_rom.r_mem[i] = wa(i);
        for (int i = 0; i < 4; i++)   dut_b.u_rom.r_mem[i] = wb(i);
        rst_b = 1'b1;
        set_a(1, 0, 0, 0, 0, 16'h0, 26'h0);
        @(posedge clk); #1;

        // Reset values, then A,B,C,D in order
        tick_a(ex(32'h0, 32'h0, 1, 0, 32'h0, 0));
        tick_a(ex(32'h0, 32'h0, 1, 0, 32'h0, 0));
        set_a(0, 0, 0, 0, 0, 16'h0, 26'h0);
        tick_a(ex(wa(0), 32'h00, 1, 1, 32'h04, 0));
        tick_a(ex(wa(1), 32'h04, 1, 1, 32'h08, 0));
        tick_a(ex(wa(2), 32'h08, 1, 1, 32'h0C, 0));
        tick_a(ex(wa(3), 32'h0C, 1, 1, 32'h10, 0));

        // Reset mid-run, then stall 3 cycles on B
        set_a(1, 0, 0, 0, 0, 16'h0, 26'h0);
        tick_a(ex(32'h0, 32'h0, 1, 0, 32'h0, 0));
        set_a(0, 0, 0, 0, 0, 16'h0, 26'h0);
        tick_a(ex(wa(0), 32'h00, 1, 1, 32'h04, 0));
        tick_a(ex(wa(1), 32'h04, 1, 1, 32'h08, 0));
        set_a(0, 1, 0, 0, 0, 16'h0, 26'h0);
        for (int i = 0; i < 3; i++) tick_a(ex(wa(1), 32'h04, 1, 1, 32'h08, 0));
        set_a(0, 0, 0, 0, 0, 16'h0, 26'h0);
        tick_a(ex(wa(2), 32'h08, 1, 1, 32'h0C, 0));

        // Jump to word 0x10 from instr_pc 8; jump held into the bubble is ignored
        set_a(0, 0, 1, 0, 0, 16'h0, 26'h10);
        tick_a(ex(32'h0, 32'h0, 0, 0, 32'h40, 0));
        set_a(0, 0, 1, 0, 0, 16'h0, 26'h3);
        tick_a(ex(wa(16), 32'h40, 1, 1, 32'h44, 0));
        // Jump under stall is ignored, then taken once stall drops
        set_a(0, 1, 1, 0, 0, 16'h0, 26'h8);
        tick_a(ex(wa(16), 32'h40, 1, 1, 32'h44, 0));
        set_a(0, 0, 1, 0, 0, 16'h0, 26'h8);
        tick_a(ex(32'h0, 32'h0, 0, 0, 32'h20, 0));
        set_a(0, 0, 0, 0, 0, 16'h0, 26'h0);
        tick_a(ex(wa(8), 32'h20, 1, 1, 32'h24, 0));

        // Backward taken branch from 0x20 by -2 words -> 0x1C
        set_a(0, 0, 0, 1, 1, 16'hFFFE, 26'h0);
        tick_a(ex(32'h0, 32'h0, 0, 0, 32'h1C, 0));
        set_a(0, 0, 0, 0, 0, 16'h0, 26'h0);
        tick_a(ex(wa(7), 32'h1C, 1, 1, 32'h20, 0));
        tick_a(ex(wa(8), 32'h20, 1, 1, 32'h24, 0));
        // Not taken: sequential, no bubble
        set_a(0, 0, 0, 1, 0, 16'hFFFE, 26'h0);
        tick_a(ex(wa(9), 32'h24, 1, 1, 32'h28, 0));
        // Jump and taken branch together: jump wins -> 0xC0
        set_a(0, 0, 1, 1, 1, 16'h0010, 26'h30);
        tick_a(ex(32'h0, 32'h0, 0, 0, 32'hC0, 0));
        set_a(0, 0, 0, 0, 0, 16'h0, 26'h0);
        tick_a(ex(wa(48), 32'hC0, 1, 1, 32'hC4, 0));
        // Forward branch +4 words from 0xC0 -> 0xD4
        set_a(0, 0, 0, 1, 1, 16'h0004, 26'h0);
        tick_a(ex(32'h0, 32'h0, 0, 0, 32'hD4, 0));
        set_a(0, 0, 0, 0, 0, 16'h0, 26'h0);
        tick_a(ex(wa(53), 32'hD4, 1, 1, 32'hD8, 0));

        // Halt word at word 5
        dut_a.u_rom.r_mem[5] = 32'hFFFF_FFFF;
        set_a(1, 0, 0, 0, 0, 16'h0, 26'h0);
        tick_a(ex(32'h0, 32'h0, 1, 0, 32'h0, 0));
        set_a(0, 0, 0, 0, 0, 16'h0, 26'h0);
        for (int i = 0; i < 5; i++)
            tick_a(ex(wa(i), 32'(4 * i), 1, 1, 32'(4 * i + 4), 0));
        // Redirect while pc points at the halt word: no halt
        set_a(0, 0, 1, 0, 0, 16'h0, 26'h2);
        tick_a(ex(32'h0, 32'h0, 0, 0, 32'h08, 0));
        set_a(0, 0, 0, 0, 0, 16'h0, 26'h0);
        tick_a(ex(wa(2), 32'h08, 1, 1, 32'h0C, 0));
        tick_a(ex(wa(3), 32'h0C, 1, 1, 32'h10, 0));
        tick_a(ex(wa(4), 32'h10, 1, 1, 32'h14, 0));
        tick_a(ex(32'h0, 32'h0, 0, 0, 32'h14, 1));
        // HALT ignores stall and redirects
        set_a(0, 1, 1, 0, 0, 16'h0, 26'h2);
        tick_a(ex(32'h0, 32'h0, 0, 0, 32'h14, 1));
        set_a(0, 0, 0, 0, 0, 16'h0, 26'h0);
        tick_a(ex(32'h0, 32'h0, 0, 0, 32'h14, 1));
        set_a(1, 0, 0, 0, 0, 16'h0, 26'h0);
        tick_a(ex(32'h0, 32'h0, 1, 0, 32'h0, 0));
        set_a(0, 0, 0, 0, 0, 16'h0, 26'h0);
        tick_a(ex(wa(0), 32'h00, 1, 1, 32'h04, 0));
        set_a(1, 0, 0, 0, 0, 16'h0, 26'h0);

        // 4-word ROM: run past 0x0C
        tick_b(ex(32'h0, 32'h0, 1, 0, 32'h0, 0));
        rst_b = 1'b0;
        for (int i = 0; i < 4; i++)
            tick_b(ex(wb(i), 32'(4 * i), 1, 1, 32'(4 * i + 4), 0));
`ifdef IFETCH_OOB_HALT_EN
        tick_b(ex(32'h0, 32'h0, 0, 0, 32'h10, 1));
        tick_b(ex(32'h0, 32'h0, 0, 0, 32'h10, 1));
`else
        tick_b(ex(wb(0), 32'h10, 1, 1, 32'h14, 0));
        tick_b(ex(wb(1), 32'h14, 1, 1, 32'h18, 0));
`endif
        rst_b = 1'b1;

        repeat (3) @(posedge clk);
        #4;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL drain: %0d/%0d expectations never compared, want 0", q_a.size(), q_b.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
